// File: rtl/i2s_pcm_receiver.sv
// -----------------------------------------------------------------------------
// i2s_pcm_receiver
//
// Oversampling I2S deserializer. It samples the I2S pins on the system clock
// and recovers left/right PCM words. Each aligned stereo pair is presented to
// the downstream modulator with a one-cycle valid strobe. The receiver is
// held idle while the pins carry a native DSD stream.
//
// Ports
//   clk        system clock; must run at least 4x the BCK frequency
//   rst_n      asynchronous active-low reset
//   i2s_bck    I2S bit clock (asynchronous to clk)
//   i2s_lrclk  word select: 0 = left, 1 = right
//   i2s_data   serial data, MSB first
//   dsd_on     1 = pins carry DSD; receiver is forced idle
//   pcm_l      last committed left sample (MSB-aligned, zero-filled LSBs)
//   pcm_r      last committed right sample
//   pcm_valid  one-cycle pulse when a new pcm_l/pcm_r pair is committed
//   locked     stream is aligned and error-free
//   frame_err  one-cycle pulse on a slot-length violation
// -----------------------------------------------------------------------------
module i2s_pcm_receiver #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned MIN_BITS = 16,
    parameter int unsigned SLOT_MAX = 32,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2s_bck,
    input  logic             i2s_lrclk,
    input  logic             i2s_data,
    input  logic             dsd_on,
    output logic [WIDTH-1:0] pcm_l,
    output logic [WIDTH-1:0] pcm_r,
    output logic             pcm_valid,
    output logic             locked,
    output logic             frame_err
);

    // Bit counter must hold SLOT_MAX+1 (its saturation value).
    localparam int unsigned CNT_W = $clog2(SLOT_MAX + 2);
    // Timeout counter must hold TIMEOUT.
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state;

    // Pin synchronizers and BCK edge detection.
    logic               bck_s1, bck_s2, bck_h;
    logic               lr_s1, lr_s2;
    logic               dat_s1, dat_s2;

    // Registered edge strobe with data/word-select aligned to it.
    logic               rise_q;
    logic               lr_q;
    logic               dat_q;

    // Word-select value seen at the previous BCK rising edge.
    logic               lr_hist;

    // Slot assembly.
    logic [WIDTH-1:0]   word;
    logic [CNT_W-1:0]   bit_cnt;

    // Frame assembly.
    logic [WIDTH-1:0]   pend_l;
    logic               pend_vld;
    logic               good_seen;

    logic [TMO_W-1:0]   tmo;

    // Combinational helpers.
    logic [WIDTH-1:0]   word_shift;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic               lr_change;
    logic               slot_bad;
    logic               tmo_hit;

    // Two-flop synchronizers, BCK history flop, and one-cycle edge strobe.
    // The extra register stage aligns commits to three clk edges after the
    // first edge that samples BCK high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_s1  <= 1'b0;
            bck_s2  <= 1'b0;
            bck_h   <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
            rise_q  <= 1'b0;
            lr_q    <= 1'b0;
            dat_q   <= 1'b0;
            lr_hist <= 1'b0;
        end else begin
            bck_s1  <= i2s_bck;
            bck_s2  <= bck_s1;
            bck_h   <= bck_s2;
            lr_s1   <= i2s_lrclk;
            lr_s2   <= lr_s1;
            dat_s1  <= i2s_data;
            dat_s2  <= dat_s1;
            rise_q  <= bck_s2 & ~bck_h;
            lr_q    <= lr_s2;
            dat_q   <= dat_s2;
            // Tracked even while idle so alignment after DSD sees a fresh value.
            if (rise_q) begin
                lr_hist <= lr_q;
            end
        end
    end

    // Next word/count for the current bit, slot checks and timeout detect.
    always_comb begin
        word_shift  = word;
        bit_cnt_inc = bit_cnt;
        lr_change   = 1'b0;
        slot_bad    = 1'b0;
        tmo_hit     = 1'b0;

        // Bits beyond WIDTH shift the marker out entirely and are dropped.
        if (dat_q) begin
            word_shift = word | (MSB_ONE >> bit_cnt);
        end

        if (bit_cnt != CNT_W'(SLOT_MAX + 1)) begin
            bit_cnt_inc = bit_cnt + CNT_W'(1);
        end

        lr_change = (lr_q != lr_hist);
        slot_bad  = (bit_cnt_inc < CNT_W'(MIN_BITS)) ||
                    (bit_cnt_inc > CNT_W'(SLOT_MAX));

        // Fires on the edge at which the counter reaches TIMEOUT.
        tmo_hit = !rise_q && (tmo >= TMO_W'(TIMEOUT - 1));
    end

    // Timeout counter: cleared by every BCK rising edge, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo <= '0;
        end else if (rise_q) begin
            tmo <= '0;
        end else if (tmo != TMO_W'(TIMEOUT)) begin
            tmo <= tmo + TMO_W'(1);
        end
    end

    // Protocol state machine, slot assembly and registered outputs.
    // Priority: DSD override, then timeout, then slot processing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word      <= '0;
            bit_cnt   <= '0;
            pend_l    <= '0;
            pend_vld  <= 1'b0;
            good_seen <= 1'b0;
            pcm_l     <= '0;
            pcm_r     <= '0;
            pcm_valid <= 1'b0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            frame_err <= 1'b0;

            if (dsd_on || tmo_hit) begin
                state     <= ST_IDLE;
                locked    <= 1'b0;
                word      <= '0;
                bit_cnt   <= '0;
                pend_vld  <= 1'b0;
                good_seen <= 1'b0;
            end else if (rise_q) begin
                if (!lr_change) begin
                    word    <= word_shift;
                    bit_cnt <= bit_cnt_inc;
                end else begin
                    // Slot boundary: the bit just sampled was the LSB of the
                    // slot belonging to the previous word-select value.
                    word    <= '0;
                    bit_cnt <= '0;
                    if (state == ST_IDLE) begin
                        // Alignment only; the partial slot is discarded.
                        state     <= ST_SYNC;
                        pend_vld  <= 1'b0;
                        good_seen <= 1'b0;
                    end else if (slot_bad) begin
                        frame_err <= 1'b1;
                        locked    <= 1'b0;
                        pend_vld  <= 1'b0;
                        good_seen <= 1'b0;
                        state     <= ST_SYNC;
                    end else if (!lr_hist) begin
                        pend_l   <= word_shift;
                        pend_vld <= 1'b1;
                    end else begin
                        pend_vld <= 1'b0;
                        // A right slot without a preceding left is ignored.
                        if (pend_vld) begin
                            if ((state == ST_RUN) || good_seen) begin
                                state     <= ST_RUN;
                                locked    <= 1'b1;
                                pcm_l     <= pend_l;
                                pcm_r     <= word_shift;
                                pcm_valid <= 1'b1;
                            end else begin
                                good_seen <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_pcm_receiver.sv
`timescale 1ns/1ps
module tb_i2s_pcm_receiver;

    localparam int unsigned WIDTH = 24;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             bck    = 1'b0;
    logic             lrclk  = 1'b0;
    logic             data   = 1'b0;
    logic             dsd_on = 1'b0;
    logic [WIDTH-1:0] pcm_l;
    logic [WIDTH-1:0] pcm_r;
    logic             pcm_valid;
    logic             locked;
    logic             frame_err;

    int n_vec = 0;
    int n_mis = 0;

    // Cycle bookkeeping: cyc counts posedges; monitor samples at negedge.
    int cyc            = 0;
    int last_rise_cyc  = 0;
    int n_valid        = 0;
    int n_err          = 0;
    int last_valid_cyc = -1;
    int lock_fall_cyc  = -1;
    int long_pulse     = 0;
    int spur_chg       = 0;

    logic [WIDTH-1:0] prev_l     = '0;
    logic [WIDTH-1:0] prev_r     = '0;
    logic             prev_valid = 1'b0;
    logic             prev_err   = 1'b0;
    logic             prev_lock  = 1'b0;
    logic             prev_rst   = 1'b0;

    int v0, v1, v2, v3, e0, e1, e2, rc;

    i2s_pcm_receiver #(
        .WIDTH    (WIDTH),
        .MIN_BITS (16),
        .SLOT_MAX (32),
        .TIMEOUT  (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2s_bck   (bck),
        .i2s_lrclk (lrclk),
        .i2s_data  (data),
        .dsd_on    (dsd_on),
        .pcm_l     (pcm_l),
        .pcm_r     (pcm_r),
        .pcm_valid (pcm_valid),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (pcm_valid) begin
            n_valid        = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (frame_err) n_err = n_err + 1;
        if ((pcm_valid && prev_valid) || (frame_err && prev_err)) long_pulse = long_pulse + 1;
        if (rst_n && prev_rst && !pcm_valid && ((pcm_l != prev_l) || (pcm_r != prev_r)))
            spur_chg = spur_chg + 1;
        if (prev_lock && !locked) lock_fall_cyc = cyc;
        prev_l     = pcm_l;
        prev_r     = pcm_r;
        prev_valid = pcm_valid;
        prev_err   = frame_err;
        prev_lock  = locked;
        prev_rst   = rst_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One BCK period of 8 clk; lrclk/data change with the falling BCK edge.
    task automatic send_bit(input logic lr, input logic d);
        bck   = 1'b0;
        lrclk = lr;
        data  = d;
        repeat (4) @(posedge clk);
        #1;
        bck           = 1'b1;
        last_rise_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // I2S slot: the word-select flips for the LSB (one-bit delay format).
    task automatic send_slot(input logic lr, input logic [31:0] slot, input int n);
        for (int i = 0; i < n; i++)
            send_bit((i == n - 1) ? ~lr : lr, slot[n - 1 - i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_slot(1'b0, l, n);
        send_slot(1'b1, r, n);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rslot;
        rslot = 32'h0000_9999;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pcm_l",     32'(pcm_l),     32'h0);
        chk("rst_pcm_r",     32'(pcm_r),     32'h0);
        chk("rst_valid",     32'(pcm_valid), 32'h0);
        chk("rst_locked",    32'(locked),    32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lock, then reset mid-slot
        repeat (3) send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("pre_rst_locked", 32'(locked), 32'h1);
        for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pcm_l",  32'(pcm_l),  32'h0);
        chk("midrst_pcm_r",  32'(pcm_r),  32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit slots: alignment frame + 2 good frames before first valid
        v0 = n_valid;
        repeat (2) send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("s32_no_early_valid", 32'(n_valid), 32'(v0));
        send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("s32_first_valid", 32'(n_valid), 32'(v0 + 1));
        chk("s32_latency", 32'(last_valid_cyc), 32'(last_rise_cyc + 4));
        chk("s32_pcm_l", 32'(pcm_l), 32'h12_3456);
        chk("s32_pcm_r", 32'(pcm_r), 32'hAB_CDEF);
        chk("s32_locked", 32'(locked), 32'h1);
        repeat (2) send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("s32_one_per_frame", 32'(n_valid), 32'(v0 + 3));

        // 16-bit slots in RUN: zero-filled LSBs
        send_frame(32'h0000_8001, 32'h0000_7FFF, 16);
        settle();
        chk("s16_valid", 32'(n_valid), 32'(v0 + 4));
        chk("s16_latency", 32'(last_valid_cyc), 32'(last_rise_cyc + 4));
        chk("s16_pcm_l", 32'(pcm_l), 32'h80_0100);
        chk("s16_pcm_r", 32'(pcm_r), 32'h7F_FF00);

        // Short (8-bit) left slot while running
        v1 = n_valid;
        e0 = n_err;
        send_slot(1'b0, 32'h0000_00A5, 8);
        send_slot(1'b1, 32'h0000_7FFF, 16);
        settle();
        chk("err_pulse", 32'(n_err), 32'(e0 + 1));
        chk("err_locked", 32'(locked), 32'h0);
        chk("err_no_valid", 32'(n_valid), 32'(v1));
        chk("err_hold_l", 32'(pcm_l), 32'h80_0100);
        chk("err_hold_r", 32'(pcm_r), 32'h7F_FF00);
        send_frame(32'h0000_1111, 32'h0000_2222, 16);
        settle();
        chk("err_relock_wait", 32'(n_valid), 32'(v1));
        send_frame(32'h0000_3333, 32'h0000_4444, 16);
        settle();
        chk("err_relock_valid", 32'(n_valid), 32'(v1 + 1));
        chk("err_relock_l", 32'(pcm_l), 32'h33_3300);
        chk("err_relock_r", 32'(pcm_r), 32'h44_4400);
        chk("err_relock_lock", 32'(locked), 32'h1);

        // DSD override in the middle of a right slot
        v2 = n_valid;
        e1 = n_err;
        send_slot(1'b0, 32'h0000_5555, 16);
        for (int i = 0; i < 6; i++) send_bit(1'b1, rslot[15 - i]);
        dsd_on = 1'b1;
        @(posedge clk);
        #1;
        chk("dsd_unlock_now", 32'(locked), 32'h0);
        repeat (99) @(posedge clk);
        #1;
        dsd_on = 1'b0;
        chk("dsd_no_valid", 32'(n_valid), 32'(v2));
        chk("dsd_no_err", 32'(n_err), 32'(e1));
        chk("dsd_hold_l", 32'(pcm_l), 32'h33_3300);
        chk("dsd_hold_r", 32'(pcm_r), 32'h44_4400);
        for (int i = 6; i < 16; i++) send_bit((i == 15) ? 1'b0 : 1'b1, rslot[15 - i]);
        send_frame(32'h0000_1234, 32'h0000_5678, 16);
        settle();
        chk("dsd_relock_wait", 32'(n_valid), 32'(v2));
        send_frame(32'h0000_CAFE, 32'h0000_BEEF, 16);
        settle();
        chk("dsd_relock_valid", 32'(n_valid), 32'(v2 + 1));
        chk("dsd_relock_l", 32'(pcm_l), 32'hCA_FE00);
        chk("dsd_relock_r", 32'(pcm_r), 32'hBE_EF00);

        // BCK stops: lock drops 255 cycles after the last processed edge,
        // which lands 4 clk after BCK went high (see commit latency).
        e2 = n_err;
        lock_fall_cyc = -1;
        rc = last_rise_cyc;
        repeat (300) @(posedge clk);
        #1;
        chk("tmo_fall_cyc", 32'(lock_fall_cyc), 32'(rc + 4 + 255));
        chk("tmo_locked", 32'(locked), 32'h0);
        chk("tmo_no_err", 32'(n_err), 32'(e2));

        // Restart: alignment + 2 good frames
        v3 = n_valid;
        repeat (2) send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("tmo_relock_wait", 32'(n_valid), 32'(v3));
        send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
        settle();
        chk("tmo_relock_valid", 32'(n_valid), 32'(v3 + 1));
        chk("tmo_relock_l", 32'(pcm_l), 32'h12_3456);
        chk("tmo_relock_r", 32'(pcm_r), 32'hAB_CDEF);
        chk("tmo_relock_lock", 32'(locked), 32'h1);

        // Whole-run properties
        chk("pulse_width", 32'(long_pulse), 32'h0);
        chk("pcm_change_only_on_commit", 32'(spur_chg), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
